out_dma: RTL

- AXI4 write-only DMA that drains a 64-bit output/result BRAM into DDR.
- It is the write-direction counterpart of the BSR/activation read DMAs. It reads BRAM words at sequential word addresses and emits them as INCR write bursts.
- Sits between the output buffer and the AXI interconnect. Control and status come from the CSR block.
- Only one burst is in flight at a time: AW, then all W beats, then B.

---
 rtl/out_dma_if.sv | 35 +++
 rtl/out_dma.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/out_dma_if.sv
// AXI4 write-channel bundle (AW/W/B) between out_dma and the interconnect.
interface out_dma_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID_W   = 4
);
  logic [AXI_ID_W-1:0]     m_axi_awid;
  logic [AXI_ADDR_W-1:0]   m_axi_awaddr;
  logic [7:0]              m_axi_awlen;
  logic [2:0]              m_axi_awsize;
  logic [1:0]              m_axi_awburst;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [AXI_DATA_W-1:0]   m_axi_wdata;
  logic [AXI_DATA_W/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [AXI_ID_W-1:0]     m_axi_bid;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;

  modport master (
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
    input  m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid
  );

  modport slave (
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
    output m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid
  );
endinterface

// File: rtl/out_dma.sv
// Write-only AXI4 DMA: drains sequential output-BRAM words into DDR as INCR bursts,
// one burst in flight at a time (AW, all W beats, then B).
module out_dma #(
  parameter int                AXI_ADDR_W  = 32,
  parameter int                AXI_DATA_W  = 64,
  parameter int                AXI_ID_W    = 4,
  parameter logic [AXI_ID_W-1:0] STREAM_ID = AXI_ID_W'(2),
  parameter int                BRAM_ADDR_W = 10,
  parameter logic [7:0]        BURST_LEN   = 8'd15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [AXI_ADDR_W-1:0]  dst_addr,
  input  logic [31:0]            csr_num_beats,
  output logic                   done,
  output logic                   busy,
  output logic                   error,
  out_dma_if.master              axi,
  output logic                   bram_re,
  output logic [BRAM_ADDR_W-1:0] bram_addr,
  input  logic [AXI_DATA_W-1:0]  bram_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;
  state_t state, state_next;

  logic [AXI_ADDR_W-1:0] addr, awaddr_q;
  logic [31:0]           remaining, rem_m1;
  logic [7:0]            awlen_q, desired, burst_len, wr_cnt;
  logic [8:0]            page_lim, beats, rd_cnt;
  logic                  awvalid_q, rd_pend;
  logic [1:0]            buf_cnt, occ;
  logic [AXI_DATA_W-1:0] buf0, buf1;
  logic                  aw_fire, w_fire, w_last_fire, b_fire, wvalid, wlast;
  logic                  unused;

  assign unused = ^{axi.m_axi_bid, dst_addr[2:0]};

  // Burst length: remaining-limited, then clipped so the burst ends at the 4KB page edge.
  assign rem_m1    = remaining - 32'd1;
  assign desired   = (rem_m1 >= {24'd0, BURST_LEN}) ? BURST_LEN : rem_m1[7:0];
  assign page_lim  = ~addr[11:3];
  assign burst_len = ({1'b0, desired} <= page_lim) ? desired : page_lim[7:0];
  assign beats     = {1'b0, awlen_q} + 9'd1;

  assign wvalid      = (state == S_DATA) && (buf_cnt != 2'd0);
  assign wlast       = wvalid && (wr_cnt == awlen_q);
  assign aw_fire     = awvalid_q && axi.m_axi_awready;
  assign w_fire      = wvalid && axi.m_axi_wready;
  assign w_last_fire = w_fire && wlast;
  assign b_fire      = (state == S_RESP) && axi.m_axi_bvalid;

  // A read is allowed only if its word still has a slot after this cycle's push/pop.
  assign occ     = buf_cnt + {1'b0, rd_pend} - {1'b0, w_fire};
  assign bram_re = (state == S_DATA) && (rd_cnt <= {1'b0, awlen_q}) && (occ <= 2'd1);

  assign axi.m_axi_awid    = STREAM_ID;
  assign axi.m_axi_awaddr  = awaddr_q;
  assign axi.m_axi_awlen   = awlen_q;
  assign axi.m_axi_awsize  = 3'b011;
  assign axi.m_axi_awburst = 2'b01;
  assign axi.m_axi_awvalid = awvalid_q;
  assign axi.m_axi_wdata   = buf0;
  assign axi.m_axi_wstrb   = '1;
  assign axi.m_axi_wlast   = wlast;
  assign axi.m_axi_wvalid  = wvalid;
  assign axi.m_axi_bready  = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (start) state_next = (csr_num_beats == 32'd0) ? S_DONE : S_ADDR;
      S_ADDR: if (aw_fire) state_next = S_DATA;
      S_DATA: if (w_last_fire) state_next = S_RESP;
      S_RESP: if (b_fire) begin
        if (axi.m_axi_bresp != 2'b00 || remaining == 32'd0) state_next = S_DONE;
        else                                                state_next = S_ADDR;
      end
      S_DONE: if (!start) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done      <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      rd_pend   <= 1'b0;
      buf_cnt   <= '0;
      buf0      <= '0;
      buf1      <= '0;
      bram_addr <= '0;
    end else begin
      done    <= (state_next == S_DONE);
      busy    <= (state_next == S_ADDR) || (state_next == S_DATA) || (state_next == S_RESP);
      rd_pend <= bram_re;

      unique case (state)
        S_IDLE: if (start) begin
          addr      <= {dst_addr[AXI_ADDR_W-1:3], 3'b000};
          remaining <= csr_num_beats;
          error     <= 1'b0;
          bram_addr <= '0;
        end
        S_ADDR: begin
          if (!awvalid_q) begin
            awaddr_q  <= addr;
            awlen_q   <= burst_len;
            awvalid_q <= 1'b1;
          end else if (axi.m_axi_awready) begin
            awvalid_q <= 1'b0;
          end
          rd_cnt <= '0;
          wr_cnt <= '0;
        end
        S_DATA: if (w_last_fire) begin
          remaining <= remaining - 32'(beats);
          addr      <= addr + (AXI_ADDR_W'(beats) << 3);
        end
        S_RESP: if (b_fire && axi.m_axi_bresp != 2'b00) error <= 1'b1;
        default: ;
      endcase

      if (bram_re) begin
        bram_addr <= bram_addr + 1'b1;
        rd_cnt    <= rd_cnt + 9'd1;
      end
      if (w_fire) wr_cnt <= wr_cnt + 8'd1;

      // Head is always buf0; an arriving word lands behind whatever survives this cycle's pop.
      unique case ({rd_pend, w_fire})
        2'b01: buf0 <= buf1;
        2'b10: if (buf_cnt == 2'd0) buf0 <= bram_rdata;
               else                 buf1 <= bram_rdata;
        2'b11: if (buf_cnt == 2'd1) buf0 <= bram_rdata;
               else begin
                 buf0 <= buf1;
                 buf1 <= bram_rdata;
               end
        default: ;
      endcase
      buf_cnt <= buf_cnt + {1'b0, rd_pend} - {1'b0, w_fire};
    end
  end

endmodule
